// File: rtl/aligner_regs_pkg.sv
// Register map constants, field positions, APB FSM states and CTRL field checker for the aligner.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package aligner_regs_pkg;

  // Byte addresses of the implemented registers.
  localparam int unsigned CTRL_ADDR   = 32'h000;
  localparam int unsigned STATUS_ADDR = 32'h00C;
  localparam int unsigned IRQEN_ADDR  = 32'h0F0;
  localparam int unsigned IRQ_ADDR    = 32'h0F4;

  // CTRL fields.
  localparam int CTRL_SIZE_LSB   = 0;
  localparam int CTRL_SIZE_W     = 3;
  localparam int CTRL_OFFSET_LSB = 8;
  localparam int CTRL_OFFSET_W   = 2;
  localparam int CTRL_CLR_BIT    = 16;

  // STATUS fields.
  localparam int STATUS_DROP_LSB = 0;
  localparam int STATUS_DROP_W   = 8;
  localparam int STATUS_RX_LSB   = 8;
  localparam int STATUS_TX_LSB   = 16;

  // IRQ / IRQEN bit indices.
  localparam int IRQ_W            = 5;
  localparam int IRQ_RX_EMPTY     = 0;
  localparam int IRQ_RX_FULL      = 1;
  localparam int IRQ_TX_EMPTY     = 2;
  localparam int IRQ_TX_FULL      = 3;
  localparam int IRQ_MAX_DROP     = 4;

  // Upper bound on inserted wait states.
  localparam int MAX_WAIT_STATES = 5;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } apb_state_e;

  // A CTRL setting is usable by the core only if SIZE is 1, 2 or 4 bytes and
  // the selected byte window stays inside the 4-byte word.
  function automatic logic ctrl_legal(input logic [CTRL_SIZE_W-1:0]   size,
                                      input logic [CTRL_OFFSET_W-1:0] offset);
    logic size_ok;
    size_ok = (size == 3'd1) || (size == 3'd2) || (size == 3'd4);
    return size_ok && (({2'b00, offset} + {1'b0, size}) <= 4'd4);
  endfunction

endpackage

// File: rtl/aligner_apb_wait_fsm.sv
// APB SETUP detection, wait-state counter and registered pready generation.
// Latency: pready rises WAIT_STATES cycles after the first ACCESS cycle (0 -> first ACCESS cycle).
// Backpressure: holds pready low while counting; psel dropping in ACCESS aborts back to IDLE.
//
// Ports: pclk/preset_n clock and async reset; psel/penable APB phase inputs;
//        pready registered completion strobe; done_nxt asserted the cycle before pready,
//        so the parent can register response data alongside pready.
module aligner_apb_wait_fsm
  import aligner_regs_pkg::*;
#(
  parameter int WAIT_STATES = 1
) (
  input  logic pclk,
  input  logic preset_n,
  input  logic psel,
  input  logic penable,
  output logic pready,
  output logic done_nxt
);

  if (WAIT_STATES < 0 || WAIT_STATES > MAX_WAIT_STATES) begin : g_ws_check
    $error("aligner_apb_wait_fsm: WAIT_STATES must be in 0..5");
  end

  localparam logic [3:0] WS = 4'(WAIT_STATES);

  apb_state_e state;
  logic [2:0] cnt;
  logic [3:0] cnt_inc;
  logic       setup;
  logic       access_step;

  assign setup       = psel & ~penable;
  assign access_step = psel & penable;
  assign cnt_inc     = {1'b0, cnt} + 4'd1;

  // ACCESS covers the cycles with pready low; DONE is the single completion
  // cycle with pready high. With no wait states SETUP goes straight to DONE.
  always_comb begin
    done_nxt = 1'b0;
    if (state == IDLE && setup && WS == 4'd0)
      done_nxt = 1'b1;
    else if (state == ACCESS && access_step && cnt_inc == WS)
      done_nxt = 1'b1;
  end

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      state  <= IDLE;
      cnt    <= '0;
      pready <= 1'b0;
    end else begin
      pready <= done_nxt;
      case (state)
        IDLE: begin
          if (setup) begin
            cnt   <= '0;
            state <= done_nxt ? DONE : ACCESS;
          end
        end
        ACCESS: begin
          if (!psel) begin
            state <= IDLE;
          end else if (done_nxt) begin
            state <= DONE;
          end else if (access_step) begin
            cnt <= cnt_inc[2:0];
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/aligner_apb_regs.sv
// APB completer and CTRL/STATUS/IRQEN/IRQ register file of the aligner; drives the level interrupt.
// Latency: WAIT_STATES+1 ACCESS cycles per transfer; ctrl_clr one cycle after completion; irq one cycle after IRQ.
// Backpressure: pready held low for WAIT_STATES ACCESS cycles; aborted transfers have no side effect.
//
// Ports: APB completer (pclk, preset_n, paddr, pwrite, psel, penable, pwdata, pready, prdata, pslverr);
//        core controls ctrl_size/ctrl_offset/ctrl_clr; core status cnt_drop/rx_lvl/tx_lvl;
//        core event pulses irq_evt[4:0]; level interrupt irq.
module aligner_apb_regs
  import aligner_regs_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 32,
  parameter int WAIT_STATES = 1,
  parameter int LVL_W       = 4
) (
  input  logic                     pclk,
  input  logic                     preset_n,
  input  logic [ADDR_W-1:0]        paddr,
  input  logic                     pwrite,
  input  logic                     psel,
  input  logic                     penable,
  input  logic [DATA_W-1:0]        pwdata,
  output logic                     pready,
  output logic [DATA_W-1:0]        prdata,
  output logic                     pslverr,
  output logic [CTRL_SIZE_W-1:0]   ctrl_size,
  output logic [CTRL_OFFSET_W-1:0] ctrl_offset,
  output logic                     ctrl_clr,
  input  logic [7:0]               cnt_drop,
  input  logic [LVL_W-1:0]         rx_lvl,
  input  logic [LVL_W-1:0]         tx_lvl,
  input  logic [IRQ_W-1:0]         irq_evt,
  output logic                     irq
);

  logic done_nxt;

  aligner_apb_wait_fsm #(
    .WAIT_STATES (WAIT_STATES)
  ) u_wait_fsm (
    .pclk     (pclk),
    .preset_n (preset_n),
    .psel     (psel),
    .penable  (penable),
    .pready   (pready),
    .done_nxt (done_nxt)
  );

  logic [IRQ_W-1:0] irqen_q;
  logic [IRQ_W-1:0] irq_q;

  // Address decode.
  logic hit_ctrl, hit_status, hit_irqen, hit_irq, aligned;
  assign aligned    = (paddr[1:0] == 2'b00);
  assign hit_ctrl   = (paddr == ADDR_W'(CTRL_ADDR));
  assign hit_status = (paddr == ADDR_W'(STATUS_ADDR));
  assign hit_irqen  = (paddr == ADDR_W'(IRQEN_ADDR));
  assign hit_irq    = (paddr == ADDR_W'(IRQ_ADDR));

  logic [CTRL_SIZE_W-1:0]   wr_size;
  logic [CTRL_OFFSET_W-1:0] wr_offset;
  assign wr_size   = pwdata[CTRL_SIZE_LSB +: CTRL_SIZE_W];
  assign wr_offset = pwdata[CTRL_OFFSET_LSB +: CTRL_OFFSET_W];

  // Only a subset of write-data bits maps to register fields.
  logic unused_pwdata;
  assign unused_pwdata = ^pwdata;

  logic [DATA_W-1:0] rd_data;
  logic              dec_err;

  always_comb begin
    rd_data = '0;
    dec_err = 1'b0;
    if (!aligned) begin
      dec_err = 1'b1;
    end else if (hit_ctrl) begin
      rd_data[CTRL_SIZE_LSB +: CTRL_SIZE_W]     = ctrl_size;
      rd_data[CTRL_OFFSET_LSB +: CTRL_OFFSET_W] = ctrl_offset;
      if (pwrite && !ctrl_legal(wr_size, wr_offset))
        dec_err = 1'b1;
    end else if (hit_status) begin
      rd_data[STATUS_DROP_LSB +: STATUS_DROP_W] = cnt_drop;
      rd_data[STATUS_RX_LSB +: LVL_W]           = rx_lvl;
      rd_data[STATUS_TX_LSB +: LVL_W]           = tx_lvl;
      if (pwrite)
        dec_err = 1'b1;
    end else if (hit_irqen) begin
      rd_data[IRQ_W-1:0] = irqen_q;
    end else if (hit_irq) begin
      rd_data[IRQ_W-1:0] = irq_q;
    end else begin
      dec_err = 1'b1;
    end
  end

  // The response is registered on the edge that raises pready, so read data
  // reflects register contents at the start of the completion cycle. APB holds
  // paddr/pwdata stable, so the registered pslverr still matches the decode
  // when side effects commit at the end of the completion cycle.
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      prdata  <= '0;
      pslverr <= 1'b0;
    end else begin
      prdata  <= (done_nxt && !pwrite && !dec_err) ? rd_data : '0;
      pslverr <= done_nxt && dec_err;
    end
  end

  logic commit_wr;
  assign commit_wr = psel & penable & pready & pwrite & ~pslverr;

  logic [IRQ_W-1:0] w1c_mask;
  assign w1c_mask = (commit_wr && hit_irq) ? pwdata[IRQ_W-1:0] : '0;

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      ctrl_size   <= 3'd1;
      ctrl_offset <= '0;
      ctrl_clr    <= 1'b0;
      irqen_q     <= '0;
      irq_q       <= '0;
      irq         <= 1'b0;
    end else begin
      ctrl_clr <= 1'b0;
      if (commit_wr && hit_ctrl) begin
        ctrl_size   <= wr_size;
        ctrl_offset <= wr_offset;
        ctrl_clr    <= pwdata[CTRL_CLR_BIT];
      end
      if (commit_wr && hit_irqen)
        irqen_q <= pwdata[IRQ_W-1:0];
      // A new event wins over a same-cycle W1C of the same bit.
      irq_q <= (irq_q & ~w1c_mask) | irq_evt;
      irq   <= |(irq_q & irqen_q);
    end
  end

endmodule

// File: tb/tb_aligner_apb_regs.sv
// Directed self-checking bench for aligner_apb_regs with WAIT_STATES 3, 0 and 5 instances.
// Latency: n/a.
// Backpressure: n/a.
module tb_aligner_apb_regs;

  logic        pclk = 1'b0;
  logic        preset_n;
  logic [15:0] paddr;
  logic        pwrite;
  logic [2:0]  psel;
  logic        penable;
  logic [31:0] pwdata;
  logic [7:0]  cnt_drop;
  logic [3:0]  rx_lvl, tx_lvl;
  logic [4:0]  irq_evt;

  logic [2:0]  pready, pslverr, ctrl_clr, irq;
  logic [31:0] prdata [3];
  logic [2:0]  ctrl_size [3];
  logic [1:0]  ctrl_offset [3];

  int n_vec = 0;
  int n_err = 0;

  always #5 pclk = ~pclk;

  aligner_apb_regs #(.ADDR_W(16), .DATA_W(32), .WAIT_STATES(3), .LVL_W(4)) u_ws3 (
    .pclk(pclk), .preset_n(preset_n), .paddr(paddr), .pwrite(pwrite), .psel(psel[0]),
    .penable(penable), .pwdata(pwdata), .pready(pready[0]), .prdata(prdata[0]),
    .pslverr(pslverr[0]), .ctrl_size(ctrl_size[0]), .ctrl_offset(ctrl_offset[0]),
    .ctrl_clr(ctrl_clr[0]), .cnt_drop(cnt_drop), .rx_lvl(rx_lvl), .tx_lvl(tx_lvl),
    .irq_evt(irq_evt), .irq(irq[0]));

  aligner_apb_regs #(.ADDR_W(16), .DATA_W(32), .WAIT_STATES(0), .LVL_W(4)) u_ws0 (
    .pclk(pclk), .preset_n(preset_n), .paddr(paddr), .pwrite(pwrite), .psel(psel[1]),
    .penable(penable), .pwdata(pwdata), .pready(pready[1]), .prdata(prdata[1]),
    .pslverr(pslverr[1]), .ctrl_size(ctrl_size[1]), .ctrl_offset(ctrl_offset[1]),
    .ctrl_clr(ctrl_clr[1]), .cnt_drop(cnt_drop), .rx_lvl(rx_lvl), .tx_lvl(tx_lvl),
    .irq_evt(irq_evt), .irq(irq[1]));

  aligner_apb_regs #(.ADDR_W(16), .DATA_W(32), .WAIT_STATES(5), .LVL_W(4)) u_ws5 (
    .pclk(pclk), .preset_n(preset_n), .paddr(paddr), .pwrite(pwrite), .psel(psel[2]),
    .penable(penable), .pwdata(pwdata), .pready(pready[2]), .prdata(prdata[2]),
    .pslverr(pslverr[2]), .ctrl_size(ctrl_size[2]), .ctrl_offset(ctrl_offset[2]),
    .ctrl_clr(ctrl_clr[2]), .cnt_drop(cnt_drop), .rx_lvl(rx_lvl), .tx_lvl(tx_lvl),
    .irq_evt(irq_evt), .irq(irq[2]));

  // One APB transfer on instance d. waits = ACCESS cycles before the one with pready.
  // evt is pulsed on irq_evt during the completion cycle.
  task automatic apb_xfer(input int d, input logic wr, input logic [15:0] addr,
                          input logic [31:0] data, input logic [4:0] evt,
                          output logic [31:0] rd, output logic err, output int waits);
    @(posedge pclk); #1;
    psel[d] = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = data;
    @(posedge pclk); #1;
    penable = 1'b1;
    waits = 0;
    while (pready[d] !== 1'b1 && waits < 20) begin
      @(posedge pclk); #1;
      waits++;
    end
    n_vec++;
    if (pready[d] !== 1'b1) begin
      n_err++;
      $display("FAIL xfer_timeout inst %0d addr %h: pready=%b after %0d cycles, required 1", d, addr, pready[d], waits);
    end
    rd = prdata[d];
    err = pslverr[d];
    irq_evt = evt;
    @(posedge pclk); #1;
    psel[d] = 1'b0; penable = 1'b0; irq_evt = '0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge pclk);
    #1;
    n_vec++; if (pready[0] !== 1'b0) begin n_err++; $display("FAIL rst_pready: got %b required 0", pready[0]); end
    n_vec++; if (prdata[0] !== 32'h0) begin n_err++; $display("FAIL rst_prdata: got %h required 0", prdata[0]); end
    n_vec++; if (pslverr[0] !== 1'b0) begin n_err++; $display("FAIL rst_pslverr: got %b required 0", pslverr[0]); end
    n_vec++; if (ctrl_size[0] !== 3'd1) begin n_err++; $display("FAIL rst_size: got %0d required 1", ctrl_size[0]); end
    n_vec++; if (ctrl_offset[0] !== 2'd0) begin n_err++; $display("FAIL rst_offset: got %0d required 0", ctrl_offset[0]); end
    n_vec++; if (ctrl_clr[0] !== 1'b0) begin n_err++; $display("FAIL rst_clr: got %b required 0", ctrl_clr[0]); end
    n_vec++; if (irq[0] !== 1'b0) begin n_err++; $display("FAIL rst_irq: got %b required 0", irq[0]); end
    preset_n = 1'b1;
  endtask

  task automatic test_reset_regs();
    logic [31:0] rd; logic err; int w;
    apb_xfer(0, 1'b0, 16'h00F0, 32'h0, 5'h0, rd, err, w);
    n_vec++; if (rd !== 32'h0) begin n_err++; $display("FAIL rst_irqen_read: got %h required 0", rd); end
    apb_xfer(0, 1'b0, 16'h00F4, 32'h0, 5'h0, rd, err, w);
    n_vec++; if (rd !== 32'h0) begin n_err++; $display("FAIL rst_irq_read: got %h required 0", rd); end
    apb_xfer(0, 1'b0, 16'h0000, 32'h0, 5'h0, rd, err, w);
    n_vec++; if (rd !== 32'h1) begin n_err++; $display("FAIL rst_ctrl_read: got %h required 00000001", rd); end
  endtask

  task automatic test_wait_states();
    logic [31:0] rd; logic err; int w;
    int exp_w [3] = '{3, 0, 5};
    for (int d = 0; d < 3; d++) begin
      apb_xfer(d, 1'b1, 16'h0000, 32'h0000_0102, 5'h0, rd, err, w);
      n_vec++; if (w != exp_w[d]) begin n_err++; $display("FAIL ws_latency inst %0d: got %0d required %0d", d, w, exp_w[d]); end
      n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL ws_pslverr inst %0d: got %b required 0", d, err); end
      n_vec++; if (ctrl_size[d] !== 3'd2) begin n_err++; $display("FAIL ws_size inst %0d: got %0d required 2", d, ctrl_size[d]); end
      n_vec++; if (ctrl_offset[d] !== 2'd1) begin n_err++; $display("FAIL ws_offset inst %0d: got %0d required 1", d, ctrl_offset[d]); end
    end
  endtask

  task automatic test_ctrl_errors();
    logic [31:0] rd; logic err; int w;
    apb_xfer(0, 1'b1, 16'h0000, 32'h0000_0003, 5'h0, rd, err, w);
    n_vec++; if (err !== 1'b1) begin n_err++; $display("FAIL size3_pslverr: got %b required 1", err); end
    n_vec++; if (ctrl_size[0] !== 3'd2 || ctrl_offset[0] !== 2'd1) begin n_err++;
      $display("FAIL size3_unchanged: got size %0d offset %0d required 2/1", ctrl_size[0], ctrl_offset[0]); end
    apb_xfer(0, 1'b1, 16'h0000, 32'h0000_0104, 5'h0, rd, err, w);
    n_vec++; if (err !== 1'b1) begin n_err++; $display("FAIL size4off1_pslverr: got %b required 1", err); end
    n_vec++; if (ctrl_size[0] !== 3'd2 || ctrl_offset[0] !== 2'd1) begin n_err++;
      $display("FAIL size4off1_unchanged: got size %0d offset %0d required 2/1", ctrl_size[0], ctrl_offset[0]); end
    apb_xfer(0, 1'b0, 16'h0044, 32'h0, 5'h0, rd, err, w);
    n_vec++; if (err !== 1'b1) begin n_err++; $display("FAIL unmapped_pslverr: got %b required 1", err); end
    n_vec++; if (rd !== 32'h0) begin n_err++; $display("FAIL unmapped_prdata: got %h required 0", rd); end
    apb_xfer(0, 1'b0, 16'h0002, 32'h0, 5'h0, rd, err, w);
    n_vec++; if (err !== 1'b1) begin n_err++; $display("FAIL misaligned_pslverr: got %b required 1", err); end
    apb_xfer(0, 1'b0, 16'h0000, 32'h0, 5'h0, rd, err, w);
    n_vec++; if (rd !== 32'h0000_0102 || err !== 1'b0) begin n_err++;
      $display("FAIL ctrl_readback: got %h err %b required 00000102 err 0", rd, err); end
  endtask

  task automatic test_clr();
    logic [31:0] rd; logic err; int w;
    apb_xfer(0, 1'b1, 16'h0000, 32'h0001_0004, 5'h0, rd, err, w);
    n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL clr_pslverr: got %b required 0", err); end
    n_vec++; if (ctrl_clr[0] !== 1'b1) begin n_err++; $display("FAIL clr_pulse_high: got %b required 1", ctrl_clr[0]); end
    @(posedge pclk); #1;
    n_vec++; if (ctrl_clr[0] !== 1'b0) begin n_err++; $display("FAIL clr_pulse_width: got %b required 0", ctrl_clr[0]); end
    n_vec++; if (ctrl_size[0] !== 3'd4 || ctrl_offset[0] !== 2'd0) begin n_err++;
      $display("FAIL clr_fields: got size %0d offset %0d required 4/0", ctrl_size[0], ctrl_offset[0]); end
    apb_xfer(0, 1'b0, 16'h0000, 32'h0, 5'h0, rd, err, w);
    n_vec++; if (rd !== 32'h0000_0004) begin n_err++; $display("FAIL clr_read_bit16: got %h required 00000004", rd); end
  endtask

  task automatic test_irq();
    logic [31:0] rd; logic err; int w;
    apb_xfer(0, 1'b1, 16'h00F0, 32'h0000_001F, 5'h0, rd, err, w);
    apb_xfer(0, 1'b0, 16'h00F0, 32'h0, 5'h0, rd, err, w);
    n_vec++; if (rd !== 32'h1F) begin n_err++; $display("FAIL irqen_read: got %h required 0000001f", rd); end
    @(posedge pclk); #1; irq_evt = 5'h10;
    @(posedge pclk); #1; irq_evt = 5'h00;
    n_vec++; if (irq[0] !== 1'b0) begin n_err++; $display("FAIL irq_lag: got %b required 0", irq[0]); end
    @(posedge pclk); #1;
    n_vec++; if (irq[0] !== 1'b1) begin n_err++; $display("FAIL irq_assert: got %b required 1", irq[0]); end
    apb_xfer(0, 1'b0, 16'h00F4, 32'h0, 5'h0, rd, err, w);
    n_vec++; if (rd !== 32'h10) begin n_err++; $display("FAIL irq_read: got %h required 00000010", rd); end
    apb_xfer(0, 1'b1, 16'h00F4, 32'h0000_0010, 5'h10, rd, err, w);
    apb_xfer(0, 1'b0, 16'h00F4, 32'h0, 5'h0, rd, err, w);
    n_vec++; if (rd !== 32'h10) begin n_err++; $display("FAIL irq_set_wins: got %h required 00000010", rd); end
    n_vec++; if (irq[0] !== 1'b1) begin n_err++; $display("FAIL irq_set_wins_line: got %b required 1", irq[0]); end
    apb_xfer(0, 1'b1, 16'h00F4, 32'h0000_0010, 5'h0, rd, err, w);
    apb_xfer(0, 1'b0, 16'h00F4, 32'h0, 5'h0, rd, err, w);
    n_vec++; if (rd !== 32'h0) begin n_err++; $display("FAIL irq_w1c: got %h required 0", rd); end
    n_vec++; if (irq[0] !== 1'b0) begin n_err++; $display("FAIL irq_w1c_line: got %b required 0", irq[0]); end
  endtask

  task automatic test_status();
    logic [31:0] rd; logic err; int w;
    cnt_drop = 8'hAB; rx_lvl = 4'd5; tx_lvl = 4'd2;
    apb_xfer(0, 1'b0, 16'h000C, 32'h0, 5'h0, rd, err, w);
    n_vec++; if (rd !== 32'h0002_05AB) begin n_err++; $display("FAIL status_read: got %h required 000205ab", rd); end
    n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL status_read_err: got %b required 0", err); end
    apb_xfer(0, 1'b1, 16'h000C, 32'hFFFF_FFFF, 5'h0, rd, err, w);
    n_vec++; if (err !== 1'b1) begin n_err++; $display("FAIL status_write_err: got %b required 1", err); end
  endtask

  task automatic test_abort();
    logic [31:0] rd; logic err; int w;
    logic seen;
    // psel dropped in the second ACCESS cycle of a CTRL write.
    seen = 1'b0;
    @(posedge pclk); #1;
    psel[0] = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 16'h0000; pwdata = 32'h0000_0001;
    @(posedge pclk); #1; penable = 1'b1;
    if (pready[0] !== 1'b0) seen = 1'b1;
    @(posedge pclk); #1;
    if (pready[0] !== 1'b0) seen = 1'b1;
    psel[0] = 1'b0; penable = 1'b0;
    repeat (6) begin
      @(posedge pclk); #1;
      if (pready[0] !== 1'b0) seen = 1'b1;
    end
    n_vec++; if (seen !== 1'b0) begin n_err++; $display("FAIL abort_pready: got %b required 0", seen); end
    n_vec++; if (ctrl_size[0] !== 3'd4 || ctrl_offset[0] !== 2'd0) begin n_err++;
      $display("FAIL abort_regs: got size %0d offset %0d required 4/0", ctrl_size[0], ctrl_offset[0]); end

    // Reset asserted mid-ACCESS of a CTRL write: registers return to reset values.
    seen = 1'b0;
    @(posedge pclk); #1;
    psel[0] = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 16'h0000; pwdata = 32'h0000_0102;
    @(posedge pclk); #1; penable = 1'b1;
    @(posedge pclk); #1;
    preset_n = 1'b0;
    #1;
    if (pready[0] !== 1'b0) seen = 1'b1;
    @(posedge pclk); #1;
    psel[0] = 1'b0; penable = 1'b0;
    preset_n = 1'b1;
    repeat (6) begin
      @(posedge pclk); #1;
      if (pready[0] !== 1'b0) seen = 1'b1;
    end
    n_vec++; if (seen !== 1'b0) begin n_err++; $display("FAIL rst_mid_pready: got %b required 0", seen); end
    n_vec++; if (ctrl_size[0] !== 3'd1 || ctrl_offset[0] !== 2'd0) begin n_err++;
      $display("FAIL rst_mid_regs: got size %0d offset %0d required 1/0", ctrl_size[0], ctrl_offset[0]); end

    apb_xfer(0, 1'b1, 16'h0000, 32'h0000_0102, 5'h0, rd, err, w);
    n_vec++; if (w != 3 || err !== 1'b0) begin n_err++;
      $display("FAIL post_abort_xfer: got waits %0d err %b required 3/0", w, err); end
    n_vec++; if (ctrl_size[0] !== 3'd2 || ctrl_offset[0] !== 2'd1) begin n_err++;
      $display("FAIL post_abort_regs: got size %0d offset %0d required 2/1", ctrl_size[0], ctrl_offset[0]); end
  endtask

  initial begin
    preset_n = 1'b0;
    paddr = '0; pwrite = 1'b0; psel = '0; penable = 1'b0; pwdata = '0;
    cnt_drop = '0; rx_lvl = '0; tx_lvl = '0; irq_evt = '0;
    test_reset();
    test_reset_regs();
    test_wait_states();
    test_ctrl_errors();
    test_clr();
    test_irq();
    test_status();
    test_abort();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete, required completion before 500000");
    $fatal(1, "timeout");
  end

endmodule
